// File: rtl/ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : ntt_stage_sequencer
// Steps one ntt_core through every stage: read sweep, pipeline drain, delayed
// write-back. Optional abort port when NTT_SEQ_ABORT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module ntt_stage_sequencer #(
   parameter int WORDS        = 512,
   parameter int PIPE_LATENCY = 8,
   parameter int NUM_STAGES   = 12,
   parameter int MODE1_START  = 5,
   parameter int MODE2_START  = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
`ifdef NTT_SEQ_ABORT_EN
   input  logic       abort,
`endif
   output logic       busy,
   output logic       done,
   output logic [3:0] log_m,
   output logic [1:0] mode,
   output logic [9:0] i,
   output logic [8:0] upper_read_address,
   output logic [8:0] lower_read_address,
   output logic       upper_write_enable,
   output logic       lower_write_enable,
   output logic [8:0] upper_write_address,
   output logic [8:0] lower_write_address
);

   localparam int              c_DW         = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;
   localparam logic [8:0]      c_LAST_ADDR  = 9'(WORDS - 1);
   localparam logic [c_DW-1:0] c_LAST_DRAIN = c_DW'(PIPE_LATENCY - 1);
   localparam logic [3:0]      c_LAST_STAGE = 4'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_DRAIN = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   logic            r_busy;
   logic            r_done;
   logic [3:0]      r_log_m;
   logic [1:0]      r_mode;
   logic [8:0]      r_rd_addr;
   logic            r_rd_valid;
   logic [c_DW-1:0] r_drain;
   logic            r_dv [PIPE_LATENCY];
   logic [8:0]      r_da [PIPE_LATENCY];
   logic            w_abort;

`ifdef NTT_SEQ_ABORT_EN
   assign w_abort = abort & r_busy;
`else
   assign w_abort = 1'b0;
`endif

   function automatic logic [1:0] mode_of(input logic [3:0] lm);
      if (int'(lm) < MODE1_START)      return 2'd0;
      else if (int'(lm) < MODE2_START) return 2'd1;
      else                             return 2'd2;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_log_m    <= 4'd0;
         r_mode     <= 2'd0;
         r_rd_addr  <= 9'd0;
         r_rd_valid <= 1'b0;
         r_drain    <= '0;
      end else if (w_abort) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_log_m    <= 4'd0;
         r_mode     <= 2'd0;
         r_rd_addr  <= 9'd0;
         r_rd_valid <= 1'b0;
         r_drain    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_READ;
                  r_busy     <= 1'b1;
                  r_rd_valid <= 1'b1;
                  r_rd_addr  <= 9'd0;
                  r_mode     <= mode_of(4'd0);
               end
            end
            S_READ: begin
               if (r_rd_addr == c_LAST_ADDR) begin
                  r_state    <= S_DRAIN;
                  r_rd_valid <= 1'b0;
                  r_rd_addr  <= 9'd0;
                  r_drain    <= '0;
               end else begin
                  r_rd_addr  <= r_rd_addr + 9'd1;
               end
            end
            S_DRAIN: begin
               if (r_drain == c_LAST_DRAIN) r_state <= S_NEXT;
               else                         r_drain <= r_drain + c_DW'(1);
            end
            S_NEXT: begin
               if (r_log_m == c_LAST_STAGE) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= S_READ;
                  r_log_m    <= r_log_m + 4'd1;
                  r_mode     <= mode_of(r_log_m + 4'd1);
                  r_rd_valid <= 1'b1;
                  r_rd_addr  <= 9'd0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_log_m <= 4'd0;
               r_mode  <= 2'd0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write-back delay line: a read issued now lands as a write PIPE_LATENCY cycles later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || w_abort) begin
         for (int k = 0; k < PIPE_LATENCY; k++) begin
            r_dv[k] <= 1'b0;
            r_da[k] <= 9'd0;
         end
      end else begin
         r_dv[0] <= r_rd_valid;
         r_da[0] <= r_rd_addr;
         for (int k = 1; k < PIPE_LATENCY; k++) begin
            r_dv[k] <= r_dv[k-1];
            r_da[k] <= r_da[k-1];
         end
      end
   end

   assign busy                = r_busy;
   assign done                = r_done;
   assign log_m               = r_log_m;
   assign mode                = r_mode;
   assign i                   = (r_mode == 2'd1) ? {1'b0, r_rd_addr} : 10'd0;
   assign upper_read_address  = r_rd_addr;
   assign lower_read_address  = r_rd_addr;
   assign upper_write_enable  = r_dv[PIPE_LATENCY-1];
   assign lower_write_enable  = r_dv[PIPE_LATENCY-1];
   assign upper_write_address = r_da[PIPE_LATENCY-1];
   assign lower_write_address = r_da[PIPE_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_ntt_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_ntt_stage_sequencer
// Scoreboard bench: stimulus queues per-cycle expected outputs, monitor compares.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ntt_stage_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
`ifdef NTT_SEQ_ABORT_EN
   logic       abort;
`endif
   logic       busy, done;
   logic [3:0] log_m;
   logic [1:0] mode;
   logic [9:0] i;
   logic [8:0] upper_read_address, lower_read_address;
   logic       upper_write_enable, lower_write_enable;
   logic [8:0] upper_write_address, lower_write_address;

   always #5 clk = ~clk;

   ntt_stage_sequencer #(
      .WORDS(4), .PIPE_LATENCY(3), .NUM_STAGES(3), .MODE1_START(1), .MODE2_START(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
`ifdef NTT_SEQ_ABORT_EN
      .abort(abort),
`endif
      .busy(busy),
      .done(done),
      .log_m(log_m),
      .mode(mode),
      .i(i),
      .upper_read_address(upper_read_address),
      .lower_read_address(lower_read_address),
      .upper_write_enable(upper_write_enable),
      .lower_write_enable(lower_write_enable),
      .upper_write_address(upper_write_address),
      .lower_write_address(lower_write_address)
   );

   typedef struct {
      logic       busy;
      logic       done;
      logic [3:0] log_m;
      logic [1:0] mode;
      logic [9:0] i;
      logic [8:0] ra;
      logic       we;
      logic [8:0] wa;
   } rec_t;

   rec_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   wr_cnt   = 0;
   int   done_cnt = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic rec_t idle_rec();
      rec_t r;
      r.busy = 1'b0; r.done = 1'b0; r.log_m = 4'd0; r.mode = 2'd0;
      r.i = 10'd0; r.ra = 9'd0; r.we = 1'b0; r.wa = 9'd0;
      return r;
   endfunction

   // Hand timing for 4 words, latency 3: 8-cycle stages (reads p0-3, writes p3-6, NEXT p7)
   function automatic rec_t run_rec(input int c);
      rec_t r;
      int   s, p;
      r = idle_rec();
      if (c == 25) begin
         r.done = 1'b1; r.log_m = 4'd2; r.mode = 2'd2;
      end else begin
         s = (c - 1) / 8;
         p = (c - 1) % 8;
         r.busy  = 1'b1;
         r.log_m = 4'(s);
         r.mode  = (s < 1) ? 2'd0 : ((s < 2) ? 2'd1 : 2'd2);
         r.ra    = (p < 4) ? 9'(p) : 9'd0;
         r.i     = (r.mode == 2'd1) ? {1'b0, r.ra} : 10'd0;
         r.we    = (p >= 3) && (p <= 6);
         r.wa    = r.we ? 9'(p - 3) : 9'd0;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      rec_t e;
      if (upper_write_enable) wr_cnt++;
      if (done) done_cnt++;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("busy",     int'(busy),                int'(e.busy));
         chk("done",     int'(done),                int'(e.done));
         chk("log_m",    int'(log_m),               int'(e.log_m));
         chk("mode",     int'(mode),                int'(e.mode));
         chk("i",        int'(i),                   int'(e.i));
         chk("upper_ra", int'(upper_read_address),  int'(e.ra));
         chk("lower_ra", int'(lower_read_address),  int'(e.ra));
         chk("upper_we", int'(upper_write_enable),  int'(e.we));
         chk("lower_we", int'(lower_write_enable),  int'(e.we));
         chk("upper_wa", int'(upper_write_address), int'(e.wa));
         chk("lower_wa", int'(lower_write_address), int'(e.wa));
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         q.push_back(idle_rec());
         #1 start = 1'b0;
      end
   endtask

   // Entered at posedge+1 with the DUT idle; start is sampled at the next edge.
   task automatic run(input int ign_a, input int ign_b, input int abort_at,
                      input int exp_wr, input int exp_done);
      int  wr0, dn0;
      bit  aborted;
      wr0     = wr_cnt;
      dn0     = done_cnt;
      aborted = 1'b0;
      start   = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk);
         q.push_back(aborted ? idle_rec() : run_rec(c));
         #1;
         start = (c == ign_a) || (c == ign_b);
`ifdef NTT_SEQ_ABORT_EN
         abort = (c == abort_at);
`endif
         if (c == abort_at) aborted = 1'b1;
      end
      @(posedge clk);
      q.push_back(idle_rec());
      #1 start = 1'b0;
`ifdef NTT_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      chk("write_count", wr_cnt - wr0, exp_wr);
      chk("done_count",  done_cnt - dn0, exp_done);
   endtask

   task automatic reset_mid_read();
      start = 1'b1;
      @(posedge clk);
      q.push_back(run_rec(1));
      #1 start = 1'b0;
      @(posedge clk);
      q.push_back(idle_rec());
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy",  int'(busy), 0);
      chk("rst_ra",    int'(upper_read_address), 0);
      chk("rst_log_m", int'(log_m), 0);
      chk("rst_we",    int'(upper_write_enable), 0);
      @(posedge clk);
      q.push_back(idle_rec());
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
`ifdef NTT_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(2);
      run(3, 25, 0, 12, 1);
      run(0, 0, 0, 12, 1);
      idle_cycles(2);
      reset_mid_read();
      idle_cycles(2);
      run(0, 0, 0, 12, 1);
`ifdef NTT_SEQ_ABORT_EN
      run(0, 0, 10, 4, 0);
      run(0, 0, 0, 12, 1);
`endif
      idle_cycles(1);
      @(negedge clk);
      #1 chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
